// File: rtl/score_keeper.sv
// score_keeper: match-scoring controller for the pong datapath.
// Turns miss indications from the ball logic into per-player BCD scores and
// sequences the match through IDLE -> SERVE -> PLAY -> OVER.
//
// Build option: define AUTO_RESTART_EN to make OVER start a new match on its
// own after RESTART_DELAY frame ticks. Without it, OVER is left only by a
// new_game event or by reset.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   frame_tick        one-cycle pulse per video frame
//   miss_left/right   level, ball past the left/right paddle
//   new_game          level from debounced button, rising edge (re)starts a match
//   score_*_ones/tens BCD score digits for the digit renderers
//   ball_en           ball motion enable, high only in PLAY
//   serve_req         one-cycle pulse on SERVE -> PLAY
//   game_over/winner  match finished / 0 = left won, 1 = right won
module score_keeper #(
  parameter int WIN_SCORE     = 11,
  parameter int SERVE_DELAY   = 60,
  parameter int RESTART_DELAY = 180
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       frame_tick,
  input  logic       miss_left,
  input  logic       miss_right,
  input  logic       new_game,
  output logic [3:0] score_l_ones,
  output logic [3:0] score_l_tens,
  output logic [3:0] score_r_ones,
  output logic [3:0] score_r_tens,
  output logic       ball_en,
  output logic       serve_req,
  output logic       game_over,
  output logic       winner
);

  typedef enum logic [1:0] {IDLE, SERVE, PLAY, OVER} state_t;

  localparam int MAX_DELAY = (SERVE_DELAY > RESTART_DELAY) ? SERVE_DELAY : RESTART_DELAY;
  localparam int CNT_W     = $clog2(MAX_DELAY + 1);
  localparam logic [CNT_W-1:0] SERVE_LAST = CNT_W'(SERVE_DELAY - 1);
`ifdef AUTO_RESTART_EN
  localparam logic [CNT_W-1:0] RESTART_LAST = CNT_W'(RESTART_DELAY - 1);
`endif
  localparam logic [6:0] WIN_BIN = 7'(WIN_SCORE);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             miss_l_q, miss_r_q, new_game_q;
  logic             ev_ml, ev_mr, ev_ng;
  logic [7:0]       l_inc, r_inc;
  logic             l_win, r_win;

  // {tens, ones} + 1 in BCD; tens cannot pass 9 because WIN_SCORE <= 99
  function automatic logic [7:0] bcd_inc(input logic [3:0] tens, input logic [3:0] ones);
    if (ones == 4'd9) return {tens + 4'd1, 4'd0};
    else              return {tens, ones + 4'd1};
  endfunction

  function automatic logic [6:0] bcd_bin(input logic [7:0] d);
    return 7'(d[7:4]) * 7'd10 + 7'(d[3:0]);
  endfunction

  assign ev_ml = miss_left  & ~miss_l_q;
  assign ev_mr = miss_right & ~miss_r_q;
  assign ev_ng = new_game   & ~new_game_q;

  always_comb begin
    l_inc = bcd_inc(score_l_tens, score_l_ones);
    r_inc = bcd_inc(score_r_tens, score_r_ones);
    l_win = (bcd_bin(l_inc) == WIN_BIN);
    r_win = (bcd_bin(r_inc) == WIN_BIN);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      cnt          <= '0;
      miss_l_q     <= 1'b0;
      miss_r_q     <= 1'b0;
      new_game_q   <= 1'b0;
      score_l_ones <= '0;
      score_l_tens <= '0;
      score_r_ones <= '0;
      score_r_tens <= '0;
      ball_en      <= 1'b0;
      serve_req    <= 1'b0;
      game_over    <= 1'b0;
      winner       <= 1'b0;
    end else begin
      miss_l_q   <= miss_left;
      miss_r_q   <= miss_right;
      new_game_q <= new_game;
      serve_req  <= 1'b0;
      ball_en    <= 1'b0;

      if (ev_ng) begin
        // New match from any state; outranks a coincident miss
        score_l_ones <= '0;
        score_l_tens <= '0;
        score_r_ones <= '0;
        score_r_tens <= '0;
        game_over    <= 1'b0;
        winner       <= 1'b0;
        cnt          <= '0;
        state        <= SERVE;
      end else begin
        case (state)
          IDLE: cnt <= '0;

          SERVE: begin
            if (frame_tick) begin
              if (cnt == SERVE_LAST) begin
                serve_req <= 1'b1;
                cnt       <= '0;
                state     <= PLAY;
              end else begin
                cnt <= cnt + 1'b1;
              end
            end
          end

          PLAY: begin
            cnt <= '0;
            if (ev_ml && ev_mr) begin
              state <= SERVE;
            end else if (ev_ml) begin
              {score_r_tens, score_r_ones} <= r_inc;
              if (r_win) begin
                state     <= OVER;
                game_over <= 1'b1;
                winner    <= 1'b1;
              end else begin
                state <= SERVE;
              end
            end else if (ev_mr) begin
              {score_l_tens, score_l_ones} <= l_inc;
              if (l_win) begin
                state     <= OVER;
                game_over <= 1'b1;
                winner    <= 1'b0;
              end else begin
                state <= SERVE;
              end
            end else begin
              // Only a cycle that stays in PLAY raises ball_en, so it is
              // registered high from the cycle after entry and drops on exit
              ball_en <= 1'b1;
            end
          end

          OVER: begin
`ifdef AUTO_RESTART_EN
            if (frame_tick) begin
              if (cnt == RESTART_LAST) begin
                score_l_ones <= '0;
                score_l_tens <= '0;
                score_r_ones <= '0;
                score_r_tens <= '0;
                game_over    <= 1'b0;
                winner       <= 1'b0;
                cnt          <= '0;
                state        <= SERVE;
              end else begin
                cnt <= cnt + 1'b1;
              end
            end
`else
            cnt <= '0;
`endif
          end

          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_score_keeper.sv
module tb_score_keeper;

  localparam int SD = 60;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       frame_tick = 1'b0;
  logic       miss_left = 1'b0;
  logic       miss_right = 1'b0;
  logic       new_game = 1'b0;
  logic [3:0] score_l_ones, score_l_tens, score_r_ones, score_r_tens;
  logic       ball_en, serve_req, game_over, winner;

  int n_vec = 0;
  int n_bad = 0;

  score_keeper #(.WIN_SCORE(11), .SERVE_DELAY(SD), .RESTART_DELAY(180)) dut (
    .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick),
    .miss_left(miss_left), .miss_right(miss_right), .new_game(new_game),
    .score_l_ones(score_l_ones), .score_l_tens(score_l_tens),
    .score_r_ones(score_r_ones), .score_r_tens(score_r_tens),
    .ball_en(ball_en), .serve_req(serve_req),
    .game_over(game_over), .winner(winner)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       ml, mr, ng;
    logic [6:0] lbin, rbin;
    logic       over, win;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic ml, input logic mr, input logic ng,
                              input int l, input int r, input logic over, input logic win);
    vec_t v;
    v.ml = ml; v.mr = mr; v.ng = ng;
    v.lbin = 7'(l); v.rbin = 7'(r);
    v.over = over; v.win = win;
    vecs.push_back(v);
  endfunction

  task automatic chk(input string nm, input logic [7:0] got, input logic [7:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_scores(input string nm, input int l, input int r);
    chk({nm, "_l_tens"}, {4'd0, score_l_tens}, 8'(l / 10));
    chk({nm, "_l_ones"}, {4'd0, score_l_ones}, 8'(l % 10));
    chk({nm, "_r_tens"}, {4'd0, score_r_tens}, 8'(r / 10));
    chk({nm, "_r_ones"}, {4'd0, score_r_ones}, 8'(r % 10));
  endtask

  task automatic tick();
    frame_tick = 1'b1;
    cyc();
    frame_tick = 1'b0;
  endtask

  // From SERVE: SD frame ticks, serve_req only at the last one, ball_en next cycle
  task automatic do_serve();
    logic early;
    early = 1'b0;
    for (int t = 1; t <= SD; t++) begin
      tick();
      if (t < SD) begin
        if (serve_req) early = 1'b1;
        cyc();
        if (serve_req) early = 1'b1;
      end
    end
    chk("serve_early", {7'd0, early}, 8'd0);
    chk("serve_req", {7'd0, serve_req}, 8'd1);
    chk("ball_en_at_serve", {7'd0, ball_en}, 8'd0);
    cyc();
    chk("serve_req_one_cycle", {7'd0, serve_req}, 8'd0);
    chk("ball_en_play", {7'd0, ball_en}, 8'd1);
  endtask

  task automatic chk_all_zero(input string nm);
    chk_scores(nm, 0, 0);
    chk({nm, "_ball_en"}, {7'd0, ball_en}, 8'd0);
    chk({nm, "_serve_req"}, {7'd0, serve_req}, 8'd0);
    chk({nm, "_game_over"}, {7'd0, game_over}, 8'd0);
    chk({nm, "_winner"}, {7'd0, winner}, 8'd0);
  endtask

  initial begin
    logic prev_over;
    logic seen;

    // Vector table: each row is played from PLAY (or from OVER once won)
    add(0, 1, 0, 1, 0, 0, 0);
    add(1, 1, 0, 1, 0, 0, 0);
    for (int k = 1; k <= 4; k++) add(1, 0, 0, 1, k, 0, 0);
    for (int k = 2; k <= 7; k++) add(0, 1, 0, k, 4, 0, 0);
    add(1, 0, 1, 0, 0, 0, 0);
    for (int k = 1; k <= 10; k++) add(0, 1, 0, k, 0, 0, 0);
    add(0, 1, 0, 11, 0, 1, 0);
    add(1, 0, 0, 11, 0, 1, 0);

    // Reset state
    #12;
    chk_all_zero("reset");
    rst_n = 1'b1;
    cyc();

    // IDLE ignores misses and frame ticks
    miss_right = 1'b1;
    cyc(); cyc(); cyc();
    miss_right = 1'b0;
    chk_scores("idle_miss", 0, 0);
    seen = 1'b0;
    for (int t = 0; t < SD + 1; t++) begin
      tick();
      if (serve_req || ball_en) seen = 1'b1;
    end
    chk("idle_no_serve", {7'd0, seen}, 8'd0);

    new_game = 1'b1;
    cyc();
    new_game = 1'b0;
    chk("start_game_over", {7'd0, game_over}, 8'd0);

    prev_over = 1'b0;
    foreach (vecs[i]) begin
      if (!prev_over) do_serve();
      miss_left  = vecs[i].ml;
      miss_right = vecs[i].mr;
      new_game   = vecs[i].ng;
      repeat (20) cyc();
      chk_scores($sformatf("vec%0d", i), int'(vecs[i].lbin), int'(vecs[i].rbin));
      chk($sformatf("vec%0d_over", i), {7'd0, game_over}, {7'd0, vecs[i].over});
      chk($sformatf("vec%0d_winner", i), {7'd0, winner}, {7'd0, vecs[i].win});
      chk($sformatf("vec%0d_ball_en", i), {7'd0, ball_en}, 8'd0);
      miss_left = 1'b0; miss_right = 1'b0; new_game = 1'b0;
      cyc();
      prev_over = vecs[i].over;
    end

    // Behaviour in OVER under frame ticks
`ifdef AUTO_RESTART_EN
    for (int t = 0; t < 179; t++) begin tick(); cyc(); end
    chk("over_before_restart", {7'd0, game_over}, 8'd1);
    tick();
    chk("auto_restart_over", {7'd0, game_over}, 8'd0);
    chk_scores("auto_restart", 0, 0);
`else
    for (int t = 0; t < 500; t++) begin tick(); cyc(); end
    chk("over_held", {7'd0, game_over}, 8'd1);
    chk_scores("over_held", 11, 0);
    chk("over_ball_en", {7'd0, ball_en}, 8'd0);
`endif

    // Right player wins a fresh match
    new_game = 1'b1;
    cyc();
    new_game = 1'b0;
    chk("restart_over", {7'd0, game_over}, 8'd0);
    chk_scores("restart", 0, 0);
    for (int p = 0; p < 11; p++) begin
      do_serve();
      miss_left = 1'b1;
      cyc(); cyc(); cyc();
      miss_left = 1'b0;
      cyc();
    end
    chk("right_win_over", {7'd0, game_over}, 8'd1);
    chk("right_win_winner", {7'd0, winner}, 8'd1);
    chk_scores("right_win", 0, 11);

    // Asynchronous reset during SERVE with a non-zero score
    new_game = 1'b1;
    cyc();
    new_game = 1'b0;
    do_serve();
    miss_right = 1'b1;
    cyc(); cyc();
    miss_right = 1'b0;
    chk_scores("pre_reset", 1, 0);
    for (int t = 0; t < 10; t++) begin tick(); cyc(); end
    #3 rst_n = 1'b0;
    #1;
    chk_all_zero("async_reset");
    cyc();
    chk_all_zero("in_reset");
    rst_n = 1'b1;
    cyc();
    new_game = 1'b1;
    cyc();
    new_game = 1'b0;
    do_serve();
    chk_scores("after_reset", 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
